uart_word_tx: RTL and testbench

Serial back-end of the acquisition readout path. Pops 16-bit samples from the UART-side sample FIFO (registered read data, 1-cycle latency). Transmits each sample as two 8N1 UART bytes, high byte first. Paces itself entirely on the FIFO empty flag and its own baud counter; the host link sees a continuous byte stream while the FIFO holds data.

---
 rtl/uart_word_tx.sv | 131 +++++++++++++
 tb/tb_uart_word_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - 16-bit sample to two 8N1 UART bytes serializer
//
// Pops one word from a registered-read FIFO and sends it as two UART bytes,
// high byte first, LSB first within each byte.
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   tx_enable   level, permits starting a new word
//   fifo_empty  FIFO empty flag, sampled only in IDLE
//   fifo_rd_en  one-cycle read strobe per word
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   tx          UART line, idle high
//   busy        high from REQ until the return to IDLE
//   word_done   one-cycle pulse after the second stop bit
//   words_sent  completed word count, wraps at 2^16
module uart_word_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 234
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done,
  output logic [15:0]           words_sent
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, REQ, LATCH, START, DATA, STOP} state_t;

  state_t                state;
  logic [BW-1:0]         baud_cnt;
  logic [2:0]            bit_cnt;
  logic                  byte_sel;
  logic [DATA_WIDTH-1:0] shreg;
  logic [7:0]            cur_byte;

  // byte_sel is already settled whenever a START or DATA bit is being set up
  assign cur_byte = byte_sel ? shreg[7:0] : shreg[15:8];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      words_sent <= '0;
      bit_cnt    <= '0;
      baud_cnt   <= '0;
      byte_sel   <= 1'b0;
      shreg      <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      word_done  <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (tx_enable && !fifo_empty) begin
            state      <= REQ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        REQ: begin
          state <= LATCH;
        end
        LATCH: begin
          // read data arrives this cycle; the start bit goes out next edge
          shreg    <= fifo_data;
          byte_sel <= 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              word_done  <= 1'b1;
              words_sent <= words_sent + 16'd1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - randomized self-checking bench for uart_word_tx
module tb_uart_word_tx;

  localparam int CPB    = 4;
  localparam int WORD_T = 2 + 20 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_data = 16'h0000;
  logic        tx;
  logic        busy;
  logic        word_done;
  logic [15:0] words_sent;

  uart_word_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tx         (tx),
    .busy       (busy),
    .word_done  (word_done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  logic        tx_log[$];
  int          rd_times[$];

  // reference model: m_t is cycles since the word's REQ cycle, -1 when idle
  int          m_t = -1;
  logic [15:0] m_word = 16'h0;
  logic        m_done = 1'b0;
  logic [15:0] m_words = 16'h0;
  logic [15:0] words_off = 16'h0;
  logic        m_started = 1'b0;

  function automatic logic frame_bit(logic [15:0] w, int b);
    logic [7:0] by;
    int p;
    by = (b < 10) ? w[15:8] : w[7:0];
    p  = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_t = -1; m_done = 1'b0; m_words = 16'h0; m_started = 1'b1;
    end else if (m_t >= 0) begin
      m_t++;
      m_done = 1'b0;
      if (m_t == WORD_T) begin
        m_t = -1; m_done = 1'b1; m_words = m_words + 16'd1;
      end
    end else begin
      m_done = 1'b0;
      if (tx_enable && !fifo_empty) begin
        m_t = 0;
        m_word = (q.size() > 0) ? q[0] : 16'h0;
      end
    end
    // FIFO environment with registered read data
    if (fifo_rd_en === 1'b1 && q.size() > 0) fifo_data <= q.pop_front();
    fifo_empty <= (q.size() - ((fifo_rd_en === 1'b1 && q.size() > 0) ? 1 : 0)) == 0;
  end

  always @(negedge clk) begin
    logic exp_tx;
    tx_log.push_back(tx);
    if (fifo_rd_en === 1'b1) rd_times.push_back(tx_log.size() - 1);
    if (m_started) begin
      exp_tx = (m_t < 2) ? 1'b1 : frame_bit(m_word, (m_t - 2) / CPB);
      check("model_tx", {31'b0, tx}, {31'b0, exp_tx});
      check("model_busy", {31'b0, busy}, {31'b0, (m_t >= 0)});
      check("model_rd_en", {31'b0, fifo_rd_en}, {31'b0, (m_t == 0)});
      check("model_word_done", {31'b0, word_done}, {31'b0, m_done});
      check("model_words_sent", {16'b0, words_sent}, {16'b0, m_words + words_off});
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rd(int n, int bound);
    for (int i = 0; i < bound && rd_times.size() < n; i++) step();
    check("rd_en_timeout", {31'b0, rd_times.size() >= n}, 32'd1);
  endtask

  function automatic logic [7:0] decode(int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx_log[s + CPB * (1 + i) + CPB / 2];
    return b;
  endfunction

  initial begin
    int n0;
    int r;
    int ones;
    logic [19:0] seq;
    seq = 20'b0101001011_0010110101;

    step(3);
    reset = 1'b1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_words", {16'b0, words_sent}, 32'd0);
    check("reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);

    // single word 0xA55A
    q.push_back(16'hA55A);
    tx_enable = 1'b1;
    wait_rd(1, 50);
    step(WORD_T + 6);
    if (rd_times.size() >= 1) begin
      r = rd_times[0];
      check("single_rd_count", rd_times.size(), 32'd1);
      check("single_tx_latch", {31'b0, tx_log[r + 1]}, 32'd1);
      check("single_tx_fall", {31'b0, tx_log[r + 2]}, 32'd0);
      for (int b = 0; b < 20; b++)
        for (int k = 0; k < CPB; k++)
          check($sformatf("single_bit%0d", b), {31'b0, tx_log[r + 2 + b * CPB + k]}, {31'b0, seq[19 - b]});
      check("single_hi", {24'b0, decode(r + 2)}, 32'h A5);
      check("single_lo", {24'b0, decode(r + 2 + 10 * CPB)}, 32'h5A);
    end
    check("single_words", {16'b0, words_sent}, 32'd1);
    tx_enable = 1'b0;

    // back-to-back, three words preloaded
    n0 = rd_times.size();
    q.push_back(16'h0001); q.push_back(16'h0203); q.push_back(16'h0405);
    step(3);
    tx_enable = 1'b1;
    wait_rd(n0 + 3, 400);
    step(WORD_T + 6);
    if (rd_times.size() >= n0 + 3) begin
      check("b2b_gap1", rd_times[n0 + 1] - rd_times[n0], 32'd83);
      check("b2b_gap2", rd_times[n0 + 2] - rd_times[n0 + 1], 32'd83);
      for (int j = 0; j < 3; j++) begin
        check("b2b_hi", {24'b0, decode(rd_times[n0 + j] + 2)}, 2 * j);
        check("b2b_lo", {24'b0, decode(rd_times[n0 + j] + 2 + 10 * CPB)}, 2 * j + 1);
      end
    end
    check("b2b_words", {16'b0, words_sent}, 32'd4);

    // empty FIFO with enable high
    n0 = rd_times.size();
    r = tx_log.size();
    step(200);
    ones = 0;
    for (int i = r; i < r + 200; i++) ones += (tx_log[i] === 1'b1) ? 1 : 0;
    check("empty_no_rd", rd_times.size() - n0, 32'd0);
    check("empty_tx_high", ones, 32'd200);
    check("empty_busy", {31'b0, busy}, 32'd0);

    // enable dropped during the first byte
    tx_enable = 1'b0;
    n0 = rd_times.size();
    q.push_back(16'h1234); q.push_back(16'h5678);
    step(3);
    tx_enable = 1'b1;
    wait_rd(n0 + 1, 50);
    step(10);
    tx_enable = 1'b0;
    step(150);
    check("drop_rd_count", rd_times.size() - n0, 32'd1);
    if (rd_times.size() > n0) begin
      check("drop_hi", {24'b0, decode(rd_times[n0] + 2)}, 32'h12);
      check("drop_lo", {24'b0, decode(rd_times[n0] + 2 + 10 * CPB)}, 32'h34);
    end
    tx_enable = 1'b1;
    wait_rd(n0 + 2, 50);
    step(WORD_T + 6);

    // reset mid-DATA
    n0 = rd_times.size();
    q.push_back(16'hABCD);
    wait_rd(n0 + 1, 50);
    step(20);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_words", {16'b0, words_sent}, 32'd0);
      check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    end
    reset = 1'b1;
    step(5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0 && q.size() < 3) q.push_back(16'($urandom));
      if ($urandom_range(0, 99) == 0) tx_enable = ~tx_enable;
      reset = ($urandom_range(0, 999) != 0);
      step();
    end
    reset = 1'b1;
    tx_enable = 1'b1;
    for (int i = 0; i < 800 && (q.size() > 0 || busy !== 1'b0); i++) step();
    check("drain_idle", {31'b0, busy}, 32'd0);

    // words_sent wrap
    tx_enable = 1'b0;
    step(2);
    words_off = 16'hFFFF - m_words;
    force dut.words_sent = 16'hFFFF;
    step();
    release dut.words_sent;
    n0 = rd_times.size();
    q.push_back(16'hC3E1);
    tx_enable = 1'b1;
    wait_rd(n0 + 1, 50);
    step(WORD_T + 6);
    check("wrap_words", {16'b0, words_sent}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
